// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: register addressing, forward-select
// encodings and the writer payload used by the forwarding/hazard block.
package fwd_hazard_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned FWD_SEL_W  = 2;

  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_ORG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2,
    FWD_WB2 = 2'd3
  } fwd_sel_e;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t rd;
    logic      wr;
  } writer_t;

  // A writer only counts when it writes and does not target the zero register.
  function automatic logic writer_valid(input writer_t w);
    return w.wr && (w.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Pipeline-stage register indices in, forward selects and hazard status out.
interface fwd_hazard_ctrl_if #(
  parameter int unsigned NUM_SRC = 2
);
  localparam int unsigned AW = fwd_hazard_ctrl_pkg::REG_ADDR_W;

  logic [AW*NUM_SRC-1:0] id_rs;
  logic [NUM_SRC-1:0]    id_rs_used;
  logic [AW*NUM_SRC-1:0] ex_rs;
  logic [AW-1:0]         rd_ex;
  logic                  reg_file_wr_ex;
  logic                  ex_is_load;
  logic [AW-1:0]         rd_mem;
  logic                  reg_file_wr_mem;
  logic [AW-1:0]         rd_wb;
  logic                  reg_file_wr_wb;
  logic                  lat_issue;
  logic [AW-1:0]         lat_rd;
  logic                  lat_done;
  logic [AW-1:0]         lat_done_rd;
  logic [2*NUM_SRC-1:0]  operand_cntl;
  logic                  stall_id;
  logic                  lat_full;
  logic                  sb_error;
  logic [31:0]           stall_cycles;

  modport master (
    output id_rs, id_rs_used, ex_rs, rd_ex, reg_file_wr_ex, ex_is_load,
           rd_mem, reg_file_wr_mem, rd_wb, reg_file_wr_wb,
           lat_issue, lat_rd, lat_done, lat_done_rd,
    input  operand_cntl, stall_id, lat_full, sb_error, stall_cycles
  );

  modport slave (
    input  id_rs, id_rs_used, ex_rs, rd_ex, reg_file_wr_ex, ex_is_load,
           rd_mem, reg_file_wr_mem, rd_wb, reg_file_wr_wb,
           lat_issue, lat_rd, lat_done, lat_done_rd,
    output operand_cntl, stall_id, lat_full, sb_error, stall_cycles
  );

endinterface

// File: rtl/lat_scoreboard.sv
// Pending-register scoreboard for long-latency ops: pending bits, in-flight
// count, sticky protocol error, and the decode-stage RAW/WAW hazard.
module lat_scoreboard
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REG_ADDR_W*NUM_SRC-1:0] id_rs,
  input  logic [NUM_SRC-1:0]           id_rs_used,
  input  logic                         lat_issue,
  input  logic [REG_ADDR_W-1:0]        lat_rd,
  input  logic                         lat_done,
  input  logic [REG_ADDR_W-1:0]        lat_done_rd,
  output logic                         sb_hazard_c,
  output logic                         lat_full,
  output logic                         sb_error
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                full_q;
  logic                issue_vld, done_vld, issue_ok, done_ok;
  logic                raw_hit, waw_hit;

  assign issue_vld = lat_issue && (lat_rd != '0);
  assign done_vld  = lat_done && (lat_done_rd != '0);
  assign done_ok   = done_vld && pend_q[lat_done_rd];
  // A retiring op frees its slot in the same cycle, so a full count can still accept.
  assign issue_ok  = issue_vld && ((cnt_q < CNT_MAX) || done_ok);
  assign waw_hit   = issue_vld && pend_q[lat_rd];

  always_comb begin
    raw_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used[i] && pend_q[id_rs[i*REG_ADDR_W +: REG_ADDR_W]]) raw_hit = 1'b1;
    end
  end

  assign sb_hazard_c = raw_hit || waw_hit;

  // Clear before set so a same-register done+issue leaves the bit pending.
  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (done_ok)  pend_d[lat_done_rd] = 1'b0;
    if (issue_ok) pend_d[lat_rd]      = 1'b1;
    pend_d[0] = 1'b0;
    if (issue_ok && !done_ok && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
    else if (done_ok && !issue_ok && (cnt_q != '0)) cnt_d = cnt_q - CNT_W'(1);
    if ((issue_vld && !issue_ok) || (done_vld && !done_ok)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      full_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      full_q <= (cnt_d == CNT_MAX);
    end
  end

  assign lat_full = full_q;
  assign sb_error = err_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding select, load-use detection and decode stall control,
// with a long-latency scoreboard and a saturating stall-cycle counter.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          WB2_EN          = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  fwd_hazard_ctrl_if.slave bus
);

  writer_t              ex_w, mem_w, wb_w, wb2_q;
  logic [2*NUM_SRC-1:0] operand_cntl_c;
  logic                 lu_match_c, load_use_c, sb_hazard_c, stall_id_c;
  logic [31:0]          stall_cnt_q;

  assign ex_w  = '{rd: bus.rd_ex,  wr: bus.reg_file_wr_ex};
  assign mem_w = '{rd: bus.rd_mem, wr: bus.reg_file_wr_mem};
  assign wb_w  = '{rd: bus.rd_wb,  wr: bus.reg_file_wr_wb};

  // Late bypass: remembers last cycle's write-back target and its validity.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb2_q <= '0;
    end else begin
      wb2_q.rd <= wb_w.rd;
      wb2_q.wr <= writer_valid(wb_w);
    end
  end

  always_comb begin
    operand_cntl_c = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (writer_valid(mem_w) && (mem_w.rd == bus.ex_rs[i*REG_ADDR_W +: REG_ADDR_W]))
        operand_cntl_c[2*i +: 2] = FWD_MEM;
      else if (writer_valid(wb_w) && (wb_w.rd == bus.ex_rs[i*REG_ADDR_W +: REG_ADDR_W]))
        operand_cntl_c[2*i +: 2] = FWD_WB;
      else if (WB2_EN && wb2_q.wr && (wb2_q.rd == bus.ex_rs[i*REG_ADDR_W +: REG_ADDR_W]))
        operand_cntl_c[2*i +: 2] = FWD_WB2;
    end
  end

  always_comb begin
    lu_match_c = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.id_rs_used[i] && (bus.id_rs[i*REG_ADDR_W +: REG_ADDR_W] == ex_w.rd))
        lu_match_c = 1'b1;
    end
  end

  assign load_use_c = bus.ex_is_load && writer_valid(ex_w) && lu_match_c;
  assign stall_id_c = load_use_c || sb_hazard_c;

  lat_scoreboard #(
    .NUM_SRC        (NUM_SRC),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .id_rs      (bus.id_rs),
    .id_rs_used (bus.id_rs_used),
    .lat_issue  (bus.lat_issue),
    .lat_rd     (bus.lat_rd),
    .lat_done   (bus.lat_done),
    .lat_done_rd(bus.lat_done_rd),
    .sb_hazard_c(sb_hazard_c),
    .lat_full   (bus.lat_full),
    .sb_error   (bus.sb_error)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_id_c && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.operand_cntl = operand_cntl_c;
  assign bus.stall_id     = stall_id_c;
  assign bus.stall_cycles = stall_cnt_q;

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, number of source operands per instruction (legal 2..3).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, max in-flight long-latency ops (legal 1..4).
REQ-003 SHALL have parameter WB2_EN, default 1, enables the late write-back bypass stage.
REQ-004 SHALL have ports:
 clk  in  1  clock; one clock, all state on rising edge
 rst  in  1  reset, synchronous, active-high
 id_rs  in  5*NUM_SRC  decode-stage source register indices, src0 in LSBs
 id_rs_used  in  NUM_SRC  decode source actually read
 ex_rs  in  5*NUM_SRC  execute-stage source register indices
 rd_ex, reg_file_wr_ex, ex_is_load  in  5,1,1  execute-stage destination, write enable, load flag
 rd_mem, reg_file_wr_mem  in  5,1  memory-stage destination, write enable
 rd_wb, reg_file_wr_wb  in  5,1  write-back destination, write enable
 lat_issue, lat_rd  in  1,5  long-latency op issued this cycle, its destination
 lat_done, lat_done_rd  in  1,5  long-latency result written this cycle, its destination
 operand_cntl  out  2*NUM_SRC  per-source forward select
 stall_id  out  1  hold decode/fetch this cycle
 lat_full  out  1  outstanding count == MAX_OUTSTANDING
 sb_error  out  1  sticky protocol-error flag
 stall_cycles  out  32  saturating count of stalled cycles

Function
REQ-005 SHALL encode forward select as FWD_ORG=0, FWD_MEM=1, FWD_WB=2, FWD_WB2=3.
REQ-006 SHALL define a writer valid when its write enable is 1 and its rd != 0.
REQ-007 SHALL select per ex source, combinationally, with priority MEM > WB > WB2 > ORG on index match with a valid writer.
REQ-008 SHALL register (rd_wb, valid) each cycle into a WB2 stage; with WB2_EN=0, FWD_WB2 is never produced.
REQ-009 SHALL assert load-use hazard when ex_is_load, valid EX writer, and rd_ex matches any id_rs with id_rs_used set.
REQ-010 SHALL hold a NUM_REGS=32 pending-bit scoreboard; bit 0 permanently 0.
REQ-011 SHALL assert scoreboard hazard when any used id_rs has its pending bit set, or when lat_issue targets a register already pending (WAW).
REQ-012 SHALL drive stall_id = load-use hazard OR scoreboard hazard, combinationally, same cycle.
REQ-013 SHALL accept lat_issue when lat_rd != 0 and (count < MAX_OUTSTANDING or lat_done accepted same cycle): set pending bit, increment count.
REQ-014 SHALL ignore lat_issue or lat_done with rd == 0 (no count or bit change, no error).
REQ-015 SHALL accept lat_done when its pending bit is set: clear bit, decrement count.
REQ-016 SHALL, on same-cycle accepted issue and done, leave count unchanged; when both name one register, the bit ends set.
REQ-017 SHALL set sb_error (sticky until reset) on rejected issue (full) or lat_done to a non-pending register; no state change for that event.
REQ-018 SHALL make count never wrap below 0 or above MAX_OUTSTANDING.
REQ-019 SHALL increment stall_cycles on every cycle stall_id=1, saturating at 0xFFFFFFFF.
REQ-020 SHALL drive lat_full from registered count, no combinational path from lat_issue.

Reset
REQ-021 SHALL, on rst=1 at a rising edge, clear scoreboard, count, WB2 valid, sb_error, stall_cycles to 0, including mid-operation; in-flight ops are forgotten.
REQ-022 SHALL, after reset, output operand_cntl=all FWD_ORG (given no valid writers), stall_id=0, lat_full=0.

Structure
REQ-023 SHALL place FWD_* encodings, NUM_REGS and REG_ADDR_W=5 in the shared core package/defines.
REQ-024 SHALL implement the scoreboard (pending bits, count, error) as one sub-module, lat_scoreboard; forwarding and load-use logic stay in the top.

Verification
REQ-025 SHALL check: ex_rs0=5, rd_mem=5 wr, rd_wb=5 wr -> operand_cntl[1:0]=1; drop MEM -> 2; drop WB next cycle -> 3 (WB2_EN=1), 0 (WB2_EN=0).
REQ-026 SHALL check: ex_is_load, rd_ex=7, id_rs1=7 used -> stall_id=1; id_rs_used[1]=0 -> stall_id=0; rd_ex=0 -> stall_id=0.
REQ-027 SHALL check: issue rd=9, then id_rs0=9 used -> stall_id=1 every cycle until lat_done rd=9; stall_id=0 the cycle after done.
REQ-028 SHALL check: MAX_OUTSTANDING=2, issue rd=3, rd=4 -> lat_full=1; issue rd=6 -> sb_error=1, bit 6 clear; issue rd=6 with done rd=3 same cycle -> accepted, count stays 2.
REQ-029 SHALL check: lat_done rd=12 never issued -> sb_error=1, count unchanged; rst mid-operation -> all state 0 next cycle.
REQ-030 SHALL check: stall_cycles preloaded near max via forced long stall saturates at 0xFFFFFFFF.
